// File: rtl/ripple_carry_adder_if.sv
// Handshake/data bundle for ripple_carry_adder; o_overflow exists only when
// RIPPLE_CARRY_ADDER_OVERFLOW_EN is defined.
interface ripple_carry_adder_if #(
    parameter int WIDTH = 2
);
    logic               i_valid;
    logic [WIDTH-1:0]   i_add_term1;
    logic [WIDTH-1:0]   i_add_term2;
    logic [WIDTH:0]     o_result;
    logic               o_valid;
`ifdef RIPPLE_CARRY_ADDER_OVERFLOW_EN
    logic               o_overflow;

    modport master (
        output i_valid, i_add_term1, i_add_term2,
        input  o_result, o_valid, o_overflow
    );
    modport slave (
        input  i_valid, i_add_term1, i_add_term2,
        output o_result, o_valid, o_overflow
    );
`else
    modport master (
        output i_valid, i_add_term1, i_add_term2,
        input  o_result, o_valid
    );
    modport slave (
        input  i_valid, i_add_term1, i_add_term2,
        output o_result, o_valid
    );
`endif
endinterface

// File: rtl/ripple_carry_adder.sv
// Registered unsigned adder built from an explicit full-adder ripple chain.
// Optional signed-overflow flag under macro RIPPLE_CARRY_ADDER_OVERFLOW_EN.
module ripple_carry_adder #(
    parameter int WIDTH = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    ripple_carry_adder_if.slave  bus
);
    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH:0]   result_d;
    logic [WIDTH:0]   result_q;
    logic             valid_d;
    logic             valid_q;

    assign carry_s[0] = 1'b0;

    // One full adder per bit; carry only ever moves from bit i to bit i+1.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum_s[i]       = bus.i_add_term1[i] ^ bus.i_add_term2[i] ^ carry_s[i];
        assign carry_s[i+1]   = (bus.i_add_term1[i] & bus.i_add_term2[i])
                              | (carry_s[i] & (bus.i_add_term1[i] ^ bus.i_add_term2[i]));
    end

    // Next-state select: load on valid, otherwise hold the last result.
    always_comb begin
        result_d = result_q;
        valid_d  = bus.i_valid;
        if (bus.i_valid) begin
            result_d = {carry_s[WIDTH], sum_s};
        end else begin
            result_d = result_q;
        end
    end

    // Output registers, cleared asynchronously by reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            result_q <= {(WIDTH+1){1'b0}};
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.o_result = result_q;
    assign bus.o_valid  = valid_q;

`ifdef RIPPLE_CARRY_ADDER_OVERFLOW_EN
    logic overflow_d;
    logic overflow_q;

    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_comb begin
        overflow_d = overflow_q;
        if (bus.i_valid) begin
            overflow_d = carry_s[WIDTH] ^ carry_s[WIDTH-1];
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Overflow flag register, same load/hold/reset behaviour as the result.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign bus.o_overflow = overflow_q;
`endif
endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder at WIDTH=2 and WIDTH=8; covers
// the overflow flag when RIPPLE_CARRY_ADDER_OVERFLOW_EN is defined.
module tb_ripple_carry_adder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ripple_carry_adder_if #(.WIDTH(2)) bus2 ();
    ripple_carry_adder_if #(.WIDTH(8)) bus8 ();

    ripple_carry_adder #(.WIDTH(2)) dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2));
    ripple_carry_adder #(.WIDTH(8)) dut8 (.i_clk(clk), .i_rst(rst), .bus(bus8));

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: what each DUT's outputs should be after the last edge.
    logic [2:0] exp_r2;
    logic       exp_v2;
    logic       exp_o2;
    logic [8:0] exp_r8;
    logic       exp_v8;
    logic       exp_o8;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic sovf(input int a, input int b, input int w);
        int sa, sb, s;
        sa = (a >= (1 << (w-1))) ? a - (1 << w) : a;
        sb = (b >= (1 << (w-1))) ? b - (1 << w) : b;
        s  = sa + sb;
        return (s > (1 << (w-1)) - 1) || (s < -(1 << (w-1)));
    endfunction

    // Advance one edge and update the reference from the inputs seen at it.
    task automatic step();
        logic r, v2, v8;
        int a2, b2, a8, b8;
        r  = rst;
        v2 = bus2.i_valid; a2 = int'(bus2.i_add_term1); b2 = int'(bus2.i_add_term2);
        v8 = bus8.i_valid; a8 = int'(bus8.i_add_term1); b8 = int'(bus8.i_add_term2);
        @(posedge clk);
        #1;
        if (r) begin
            exp_r2 = 3'd0; exp_v2 = 1'b0; exp_o2 = 1'b0;
            exp_r8 = 9'd0; exp_v8 = 1'b0; exp_o8 = 1'b0;
        end else begin
            exp_v2 = v2;
            exp_v8 = v8;
            if (v2) begin
                exp_r2 = 3'(a2 + b2);
                exp_o2 = sovf(a2, b2, 2);
            end
            if (v8) begin
                exp_r8 = 9'(a8 + b8);
                exp_o8 = sovf(a8, b8, 8);
            end
        end
    endtask

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b);
        bus8.i_valid = v; bus8.i_add_term1 = a; bus8.i_add_term2 = b;
    endtask

    task automatic drive2(input logic v, input logic [1:0] a, input logic [1:0] b);
        bus2.i_valid = v; bus2.i_add_term1 = a; bus2.i_add_term2 = b;
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, "_r2"}, 64'(bus2.o_result), 64'(exp_r2));
        check_eq({tag, "_v2"}, 64'(bus2.o_valid), 64'(exp_v2));
        check_eq({tag, "_r8"}, 64'(bus8.o_result), 64'(exp_r8));
        check_eq({tag, "_v8"}, 64'(bus8.o_valid), 64'(exp_v8));
`ifdef RIPPLE_CARRY_ADDER_OVERFLOW_EN
        check_eq({tag, "_o2"}, 64'(bus2.o_overflow), 64'(exp_o2));
        check_eq({tag, "_o8"}, 64'(bus8.o_overflow), 64'(exp_o8));
`endif
    endtask

    logic [1:0] va [4];
    logic [1:0] vb [4];
    logic [2:0] vr [4];

    initial begin
        va = '{2'b00, 2'b10, 2'b01, 2'b11};
        vb = '{2'b01, 2'b01, 2'b11, 2'b11};
        vr = '{3'b001, 3'b011, 3'b100, 3'b110};

        rst = 1'b1;
        drive2(1'b0, 2'd0, 2'd0);
        drive8(1'b0, 8'd0, 8'd0);
        step();
        step();
        check_eq("rst_result", 64'(bus8.o_result), 64'h0);
        check_eq("rst_valid", 64'(bus8.o_valid), 64'h0);

        // Load something non-zero, then reset between edges.
        rst = 1'b0;
        drive8(1'b1, 8'h03, 8'h03);
        step();
        check_eq("pre_async_result", 64'(bus8.o_result), 64'h006);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_result", 64'(bus8.o_result), 64'h0);
        check_eq("async_rst_valid", 64'(bus8.o_valid), 64'h0);
        step();
        check_eq("rst_wins_result", 64'(bus8.o_result), 64'h0);
        check_eq("rst_wins_valid", 64'(bus8.o_valid), 64'h0);
        rst = 1'b0;
        drive8(1'b0, 8'h55, 8'h66);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("idle_after_rst_result", 64'(bus8.o_result), 64'h0);
            check_eq("idle_after_rst_valid", 64'(bus8.o_valid), 64'h0);
        end

        // WIDTH=2 back-to-back vectors.
        for (int i = 0; i < 4; i++) begin
            drive2(1'b1, va[i], vb[i]);
            step();
            check_eq("w2_result", 64'(bus2.o_result), 64'(vr[i]));
            check_eq("w2_valid", 64'(bus2.o_valid), 64'h1);
        end
        drive2(1'b0, 2'd0, 2'd0);

        // WIDTH=8 full carry ripple, then zero.
        drive8(1'b1, 8'hFF, 8'h01);
        step();
        check_eq("w8_ripple", 64'(bus8.o_result), 64'h100);
        check_eq("w8_ripple_valid", 64'(bus8.o_valid), 64'h1);
        drive8(1'b1, 8'h00, 8'h00);
        step();
        check_eq("w8_zero", 64'(bus8.o_result), 64'h000);

        // Hold while i_valid is low.
        drive8(1'b1, 8'h12, 8'h34);
        step();
        check_eq("hold_load", 64'(bus8.o_result), 64'h046);
        drive8(1'b0, 8'hAA, 8'h55);
        step();
        check_eq("hold_result", 64'(bus8.o_result), 64'h046);
        check_eq("hold_valid", 64'(bus8.o_valid), 64'h0);

        // Pending input discarded by a reset pulse before its edge.
        drive8(1'b1, 8'h80, 8'h80);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_result", 64'(bus8.o_result), 64'h0);
        rst = 1'b0;
        drive8(1'b0, 8'h80, 8'h80);
        step();
        check_eq("mid_rst_no_pulse", 64'(bus8.o_valid), 64'h0);
        check_eq("mid_rst_hold", 64'(bus8.o_result), 64'h0);
        drive8(1'b1, 8'h80, 8'h80);
        step();
        check_eq("after_rst_load", 64'(bus8.o_result), 64'h100);
        check_eq("after_rst_valid", 64'(bus8.o_valid), 64'h1);

`ifdef RIPPLE_CARRY_ADDER_OVERFLOW_EN
        drive8(1'b1, 8'h7F, 8'h01);
        step();
        check_eq("ovf_7f_01_res", 64'(bus8.o_result), 64'h080);
        check_eq("ovf_7f_01", 64'(bus8.o_overflow), 64'h1);
        drive8(1'b1, 8'hFF, 8'h01);
        step();
        check_eq("ovf_ff_01_res", 64'(bus8.o_result), 64'h100);
        check_eq("ovf_ff_01", 64'(bus8.o_overflow), 64'h0);
        drive8(1'b1, 8'h80, 8'h80);
        step();
        check_eq("ovf_80_80_res", 64'(bus8.o_result), 64'h100);
        check_eq("ovf_80_80", 64'(bus8.o_overflow), 64'h1);
`endif

        // Randomized phase against the arithmetic reference.
        rst = 1'b1;
        drive2(1'b0, 2'd0, 2'd0);
        drive8(1'b0, 8'd0, 8'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rst = (($urandom % 40) == 0);
            drive2(($urandom % 4) != 0, 2'($urandom), 2'($urandom));
            drive8(($urandom % 4) != 0, 8'($urandom), 8'($urandom));
            step();
            check_model("rand");
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
